mux_16x1: RTL and testbench
===========================

Name: mux_16x1

Overview:
- Registered 16-to-1 single-bit multiplexer.
- Selects one of 16 data inputs by a 4-bit select and presents it on a flopped output one clock after sampling.
- Used as a leaf datapath block wherever a clean, glitch-free, clock-aligned selected bit is needed.

Parameters:
- None. Data width is fixed at 1 bit per input; input count is fixed at 16; select width is fixed at 4.

Ports:
- clk  input  1   System clock; all state updates on the rising edge.
- rst  input  1   Asynchronous, active-low reset (0 = reset asserted, 1 = normal operation).
- i    input  16  Data inputs; bit i[k] is input channel k, k = 0..15.
- s    input  4   Channel select, unsigned binary; value k selects i[k].
- y    output 1   Registered selected data bit.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-low.
- Reset:
  - While rst = 0, y = 0.
  - Assertion (falling edge of rst) clears y immediately, without waiting for clk.
  - Reset overrides everything; clk edges while rst = 0 have no effect.
- Normal operation (rst = 1): on every rising edge of clk, y <= i[s], where s and i are sampled at that edge.
- Latency:
  - Exactly 1 clock from sampling edge to y.
  - No combinational path from i or s to y.
  - y holds its value between rising edges even if i or s change.
- Select decode:
  - All 16 codes 4'h0..4'hF are legal and map one-to-one to i[0]..i[15].
  - No out-of-range case exists.
  - If s contains X/Z, y after the edge is don't-care. The implementation must not hang and must recover on the next edge with a known s.
- Throughput: a new selection every cycle; no handshake and no enables.
- Simultaneous events: s and i changing together before an edge is handled by the edge sampling their settled values. The selected value is the one present at the edge.
- Reset release:
  - Reset deassertion is synchronous to clk by contract; the parent provides a synchronized release.
  - The first rising edge with rst = 1 captures i[s].
- Reset mid-operation: y drops to 0 asynchronously. After release, normal capture resumes on the next rising edge; no stale value is retained.
- Power-up: y is undefined until the first reset. Benches must apply rst = 0 before checking.

Test Plan:
- Reset:
  - Hold rst = 0, i = 16'hFFFF, s = 4'h5, toggle clk -> y stays 0.
  - Release rst = 1 -> after the next rising edge, y = 1.
- Walking one:
  - For k = 0..15, set i = 16'h0001 << k and s = k -> y = 1 one edge later.
  - With s = (k+1) mod 16 -> y = 0.
- Walking zero: i = ~(16'h0001 << k), s = k -> y = 0; any other s -> y = 1.
- Latency/hold:
  - With i = 16'hA5A5, change s from 4'h0 to 4'h1 mid-cycle -> y keeps its old value (1) until the next rising edge, then becomes 0.
  - No combinational change in y is permitted.
- Async reset mid-run: with y = 1 (i = 16'h8000, s = 4'hF), pulse rst = 0 between clock edges -> y goes to 0 immediately, not at a clk edge. After release it returns to 1 on the following edge.
- Random: 1000 cycles of random i and s -> y(n+1) == i(n)[s(n)] every cycle; zero mismatches.

Source files
------------

// File: rtl/mux_16x1.sv
// Registered 16-to-1 bit multiplexer.
// Output is flopped; async active-low reset clears it.
module mux_16x1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i,
  input  logic [3:0]  s,
  output logic        y
);

  logic y_d;
  logic y_q;

  always_comb begin
    y_d = i[s];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_mux_16x1.sv
// Scoreboard bench for mux_16x1.
// Directed walking/hold/reset cases plus random traffic.
module tb_mux_16x1;

  logic        clk;
  logic        rst;
  logic [15:0] i;
  logic [3:0]  s;
  logic        y;

  int tests;
  int fails;
  logic q_exp[$];
  logic m_e;

  mux_16x1 dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .s   (s),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act,
                     input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: y=%b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic ref_sel(input logic [15:0] iv,
                                   input int sv);
    return logic'((iv >> sv) & 16'h1);
  endfunction

  // Inputs set here are sampled by the next rising edge.
  task automatic drive(input logic [15:0] iv, input logic [3:0] sv);
    i = iv;
    s = sv;
    q_exp.push_back(ref_sel(iv, int'(sv)));
  endtask

  task automatic issue(input logic [15:0] iv, input logic [3:0] sv);
    @(negedge clk);
    drive(iv, sv);
  endtask

  always @(posedge clk) begin
    if (rst && q_exp.size() > 0) begin
      #1;
      m_e = q_exp.pop_front();
      chk("scoreboard", y, m_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    i = 16'hFFFF;
    s = 4'h5;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_assert", y, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_hold", y, 1'b0);
    end
    rst = 1'b1;
    drive(16'hFFFF, 4'h5);

    for (int k = 0; k < 16; k++) begin
      w = 16'h0001 << k;
      issue(w, 4'(k));
      issue(w, 4'((k + 1) % 16));
    end

    for (int k = 0; k < 16; k++) begin
      w = ~(16'h0001 << k);
      issue(w, 4'(k));
      issue(w, 4'((k + 7) % 16));
    end

    issue(16'hA5A5, 4'h0);
    issue(16'hA5A5, 4'h1);
    #1;
    chk("hold_mid_cycle", y, 1'b1);
    #2;
    chk("hold_late", y, 1'b1);

    issue(16'h8000, 4'hF);
    @(posedge clk);
    #2;
    chk("async_pre", y, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_drop", y, 1'b0);
    @(negedge clk);
    chk("async_held", y, 1'b0);
    rst = 1'b1;
    drive(16'h8000, 4'hF);

    for (int n = 0; n < 1000; n++) begin
      issue(16'($urandom), 4'($urandom_range(15, 0)));
    end

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q_exp.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d pending expected 0", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
